subleq_mem_responder: RTL and testbench



---
 rtl/subleq_pkg.sv | 16 +
 rtl/subleq_bram_core.sv | 36 +++
 rtl/subleq_mem_responder.sv | 180 ++++++++++++++++++
 tb/tb_subleq_mem_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subleq_pkg.sv
// Shared types and constants for the SUBLEQ memory responder.
package subleq_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned LANE_W     = 8;
  localparam int unsigned LANES      = DATA_W / LANE_W;
  localparam int unsigned LANE_IDX_W = $clog2(LANES);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_SERVE,
    ST_LOAD,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/subleq_bram_core.sv
// Single-port synchronous read-first RAM; the read register holds unless re_i,
// and can return zero instead of the array word (out-of-range reads).
module subleq_bram_core #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_W    = subleq_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic                 rzero_i,
  output logic [DATA_W-1:0]    rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Output register samples the array before this edge's write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/subleq_mem_responder.sv
// Memory-side responder for the SUBLEQ CPU: word store with post-reset clear
// and a host byte-stream program loader that holds the CPU off while active.
module subleq_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_W    = subleq_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_enable,
  input  logic [63:0]          addr,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 write_en,
  input  logic                 read_en,
  output logic [DATA_W-1:0]    data_out,
  output logic                 cpu_hold,
  output logic                 addr_err,
  input  logic                 ld_start,
  input  logic [ADDR_BITS-1:0] ld_base,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_byte,
  output logic                 ld_ready,
  input  logic                 ld_end,
  output logic [ADDR_BITS:0]   load_words
);

  import subleq_pkg::*;

  localparam int unsigned WCNT_W = ADDR_BITS + 1;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_ptr_q, clr_ptr_d;
  logic [ADDR_BITS-1:0]  ld_ptr_q, ld_ptr_d;
  logic [LANE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]     asm_q, asm_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]     load_words_q, load_words_d;
  logic                  addr_err_q, addr_err_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  ld_ready_q, ld_ready_d;

  logic [ADDR_BITS-1:0]  cpu_idx_c;
  logic                  cpu_oor_c;
  logic [WCNT_W-1:0]     wcnt_inc_c;
  logic [DATA_W-1:0]     asm_ins_c;
  logic [ADDR_BITS-1:0]  mem_addr_c;
  logic [DATA_W-1:0]     mem_wdata_c;
  logic                  mem_we_c;
  logic                  mem_re_c;
  logic                  mem_rzero_c;

  assign cpu_idx_c  = addr[ADDR_BITS-1:0];
  assign cpu_oor_c  = (addr[63:ADDR_BITS] != '0);
  assign wcnt_inc_c = (wcnt_q == WCNT_W'(DEPTH)) ? wcnt_q : wcnt_q + WCNT_W'(1);

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    ld_ptr_d     = ld_ptr_q;
    byte_idx_d   = byte_idx_q;
    asm_d        = asm_q;
    wcnt_d       = wcnt_q;
    load_words_d = load_words_q;
    addr_err_d   = addr_err_q;
    mem_addr_c   = cpu_idx_c;
    mem_wdata_c  = data_in;
    mem_we_c     = 1'b0;
    mem_re_c     = 1'b0;
    mem_rzero_c  = 1'b0;
    asm_ins_c    = asm_q;
    asm_ins_c[{byte_idx_q, 3'b000} +: LANE_W] = ld_byte;

    unique case (state_q)
      ST_CLEAR: begin
        mem_addr_c  = clr_ptr_q;
        mem_wdata_c = '0;
        mem_we_c    = 1'b1;
        clr_ptr_d   = clr_ptr_q + ADDR_BITS'(1);
        if (clr_ptr_q == ADDR_BITS'(DEPTH - 1)) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        // A load request wins over any CPU access in the same cycle.
        if (ld_start) begin
          ld_ptr_d   = ld_base;
          byte_idx_d = '0;
          asm_d      = '0;
          wcnt_d     = '0;
          state_d    = ST_LOAD;
        end else if (clk_enable) begin
          mem_we_c    = write_en && !cpu_oor_c;
          mem_re_c    = read_en;
          mem_rzero_c = cpu_oor_c;
          if (cpu_oor_c && (read_en || write_en)) addr_err_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (byte_idx_q == LANE_IDX_W'(LANES - 1)) begin
            mem_addr_c  = ld_ptr_q;
            mem_wdata_c = asm_ins_c;
            mem_we_c    = 1'b1;
            ld_ptr_d    = ld_ptr_q + ADDR_BITS'(1);
            wcnt_d      = wcnt_inc_c;
            byte_idx_d  = '0;
            asm_d       = '0;
          end else begin
            asm_d      = asm_ins_c;
            byte_idx_d = byte_idx_q + LANE_IDX_W'(1);
          end
        end
        if (ld_end) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Partial word goes out zero-padded since unused lanes were cleared.
        load_words_d = wcnt_q;
        if (byte_idx_q != '0) begin
          mem_addr_c   = ld_ptr_q;
          mem_wdata_c  = asm_q;
          mem_we_c     = 1'b1;
          load_words_d = wcnt_inc_c;
        end
        wcnt_d     = load_words_d;
        byte_idx_d = '0;
        asm_d      = '0;
        state_d    = ST_SERVE;
      end
      default: state_d = ST_CLEAR;
    endcase

    cpu_hold_d = (state_d != ST_SERVE);
    ld_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= '0;
      ld_ptr_q     <= '0;
      byte_idx_q   <= '0;
      asm_q        <= '0;
      wcnt_q       <= '0;
      load_words_q <= '0;
      addr_err_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      ld_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      ld_ptr_q     <= ld_ptr_d;
      byte_idx_q   <= byte_idx_d;
      asm_q        <= asm_d;
      wcnt_q       <= wcnt_d;
      load_words_q <= load_words_d;
      addr_err_q   <= addr_err_d;
      cpu_hold_q   <= cpu_hold_d;
      ld_ready_q   <= ld_ready_d;
    end
  end

  subleq_bram_core #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (mem_addr_c),
    .wdata_i (mem_wdata_c),
    .we_i    (mem_we_c),
    .re_i    (mem_re_c),
    .rzero_i (mem_rzero_c),
    .rdata_o (data_out)
  );

  assign cpu_hold   = cpu_hold_q;
  assign addr_err   = addr_err_q;
  assign ld_ready   = ld_ready_q;
  assign load_words = load_words_q;

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Bench for subleq_mem_responder: transaction-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_subleq_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AB    = 4;
  localparam int unsigned DW    = 64;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          clk_enable = 1'b0;
  logic [63:0]   addr       = '0;
  logic [DW-1:0] data_in    = '0;
  logic          write_en   = 1'b0;
  logic          read_en    = 1'b0;
  logic [DW-1:0] data_out;
  logic          cpu_hold;
  logic          addr_err;
  logic          ld_start   = 1'b0;
  logic [AB-1:0] ld_base    = '0;
  logic          ld_valid   = 1'b0;
  logic [7:0]    ld_byte    = '0;
  logic          ld_ready;
  logic          ld_end     = 1'b0;
  logic [AB:0]   load_words;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: memory image, pending load bytes, and phase flags.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_dout     = '0;
  bit            m_err      = 1'b0;
  int            m_lw       = 0;
  int            m_clr_left = DEPTH;
  bit            m_loading  = 1'b0;
  bit            m_flushing = 1'b0;
  int            m_ptr      = 0;
  int            m_cnt      = 0;
  logic [7:0]    m_bytes[$];
  logic [7:0]    ld_q[$];

  subleq_mem_responder #(.DEPTH(DEPTH), .ADDR_BITS(AB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_enable (clk_enable),
    .addr       (addr),
    .data_in    (data_in),
    .write_en   (write_en),
    .read_en    (read_en),
    .data_out   (data_out),
    .cpu_hold   (cpu_hold),
    .addr_err   (addr_err),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .ld_end     (ld_end),
    .load_words (load_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pack_bytes();
    logic [DW-1:0] w = '0;
    foreach (m_bytes[i]) w = w | (DW'(m_bytes[i]) << (8 * i));
    return w;
  endfunction

  function automatic bit m_hold();
    return (m_clr_left > 0) || m_loading || m_flushing;
  endfunction

  task automatic model_edge();
    bit oor;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_dout = '0; m_err = 1'b0; m_lw = 0; m_clr_left = DEPTH;
      m_loading = 1'b0; m_flushing = 1'b0; m_cnt = 0; m_bytes.delete();
    end else if (m_clr_left > 0) begin
      m_clr_left--;
    end else if (m_flushing) begin
      if (m_bytes.size() > 0) begin
        m_mem[m_ptr] = pack_bytes();
        m_cnt++;
        m_bytes.delete();
      end
      m_lw = (m_cnt > DEPTH) ? DEPTH : m_cnt;
      m_flushing = 1'b0;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_bytes.push_back(ld_byte);
        if (m_bytes.size() == 8) begin
          m_mem[m_ptr] = pack_bytes();
          m_ptr = (m_ptr + 1) % DEPTH;
          m_cnt++;
          m_bytes.delete();
        end
      end
      if (ld_end) begin
        m_loading  = 1'b0;
        m_flushing = 1'b1;
      end
    end else if (ld_start) begin
      m_loading = 1'b1; m_ptr = int'(ld_base); m_cnt = 0; m_bytes.delete();
    end else if (clk_enable && (read_en || write_en)) begin
      oor = (addr >= 64'(DEPTH));
      if (oor) m_err = 1'b1;
      if (read_en) m_dout = oor ? '0 : m_mem[addr[AB-1:0]];
      if (write_en && !oor) m_mem[addr[AB-1:0]] = data_in;
    end
  endtask

  // Per-cycle compare against the model, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    model_edge();
    #1;
    chk("data_out",   data_out,          m_dout);
    chk("cpu_hold",   64'(cpu_hold),     64'(m_hold()));
    chk("ld_ready",   64'(ld_ready),     64'(m_loading));
    chk("addr_err",   64'(addr_err),     64'(m_err));
    chk("load_words", 64'(load_words),   64'(m_lw));
  end

  task automatic idle();
    clk_enable = 1'b0; read_en = 1'b0; write_en = 1'b0; addr = '0; data_in = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_end = 1'b0;
  endtask

  task automatic cpu_op(input logic [63:0] a, input bit rd, input bit wr,
                        input logic [63:0] d, input bit ce);
    addr = a; read_en = rd; write_en = wr; data_in = d; clk_enable = ce;
    @(negedge clk);
    idle();
  endtask

  task automatic read_lit(input logic [63:0] a, input logic [63:0] exp, input string nm);
    cpu_op(a, 1'b1, 1'b0, '0, 1'b1);
    chk(nm, data_out, exp);
  endtask

  task automatic rnd_op();
    logic [63:0] a;
    if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom} | 64'h100;
    else a = 64'($urandom_range(0, DEPTH - 1));
    cpu_op(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0));
  endtask

  task automatic drive_junk();
    clk_enable = 1'($urandom_range(0, 1));
    read_en    = 1'($urandom_range(0, 1));
    write_en   = 1'($urandom_range(0, 1));
    addr       = 64'($urandom_range(0, 31));
    data_in    = {$urandom, $urandom};
    ld_start   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_serve(input int max, input string nm, output int n);
    n = 0;
    while (cpu_hold && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(cpu_hold), 64'd0);
  endtask

  task automatic load_seq(input logic [AB-1:0] base, input bit gaps, input bit sep_end,
                          input bit junk);
    int n;
    idle(); ld_start = 1'b1; ld_base = base; clk_enable = 1'b1;
    @(negedge clk);
    idle();
    foreach (ld_q[i]) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0; ld_end = 1'b0; ld_byte = 8'($urandom);
        if (junk) drive_junk();
        @(negedge clk);
      end
      ld_valid = 1'b1; ld_byte = ld_q[i];
      ld_end = (i == ld_q.size() - 1) && !sep_end;
      if (junk) drive_junk();
      @(negedge clk);
    end
    if (sep_end || ld_q.size() == 0) begin
      ld_valid = 1'b0; ld_end = 1'b1;
      if (junk) drive_junk();
      @(negedge clk);
    end
    idle();
    wait_serve(20, "load_return", n);
  endtask

  initial begin
    int n;
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clear phase length and zeroed array.
    wait_serve(100, "clear_done", n);
    chk("clear_cycles", 64'(n), 64'd16);
    for (int a = 0; a < DEPTH; a++) read_lit(64'(a), 64'd0, "clear_zero");
    chk("addr_err_init", 64'(addr_err), 64'd0);

    // Basic write/read and clk_enable gating.
    cpu_op(64'd3, 1'b0, 1'b1, 64'h1234, 1'b1);
    read_lit(64'd3, 64'h1234, "wr_rd_3");
    cpu_op(64'd3, 1'b0, 1'b1, 64'h5555, 1'b0);
    read_lit(64'd3, 64'h1234, "ce_gated_wr");

    // Read-first collision.
    cpu_op(64'd5, 1'b0, 1'b1, 64'd7, 1'b1);
    cpu_op(64'd5, 1'b1, 1'b1, 64'd9, 1'b1);
    chk("rw_old", data_out, 64'd7);
    read_lit(64'd5, 64'd9, "rw_new");

    // Out-of-range access.
    cpu_op(64'h100, 1'b0, 1'b1, 64'hDEAD, 1'b1);
    chk("oor_err", 64'(addr_err), 64'd1);
    read_lit(64'h100, 64'd0, "oor_read");
    read_lit(64'd0, 64'd0, "oor_mem0");
    chk("err_sticky", 64'(addr_err), 64'd1);

    // Directed wrapping load with a partial tail word.
    ld_q.delete();
    for (int b = 1; b <= 20; b++) ld_q.push_back(8'(b));
    load_seq(4'd14, 1'b0, 1'b0, 1'b0);
    read_lit(64'd14, 64'h0807060504030201, "load_w14");
    read_lit(64'd15, 64'h100F0E0D0C0B0A09, "load_w15");
    read_lit(64'd0,  64'h0000000014131211, "load_w0");
    chk("load_words_3", 64'(load_words), 64'd3);

    // Reset in the middle of a load.
    idle(); ld_start = 1'b1; ld_base = 4'd2; clk_enable = 1'b1;
    @(negedge clk);
    idle();
    for (int b = 0; b < 5; b++) begin
      ld_valid = 1'b1; ld_byte = 8'(8'hA0 + b);
      @(negedge clk);
    end
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_serve(100, "reclear_done", n);
    chk("reclear_cycles", 64'(n), 64'd16);
    for (int a = 0; a < DEPTH; a++) read_lit(64'(a), 64'd0, "reclear_zero");
    chk("load_words_rst", 64'(load_words), 64'd0);
    chk("addr_err_rst", 64'(addr_err), 64'd0);

    // Random CPU traffic.
    repeat (300) rnd_op();

    // Random loads with gaps, separate end markers and ignored CPU traffic.
    repeat (6) begin
      ld_q.delete();
      repeat ($urandom_range(0, 40)) ld_q.push_back(8'($urandom));
      load_seq(AB'($urandom_range(0, DEPTH - 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      repeat (20) rnd_op();
    end

    // Overlong load: 140 bytes = 18 words, wraps and saturates the count.
    ld_q.delete();
    repeat (140) ld_q.push_back(8'($urandom));
    load_seq(AB'($urandom_range(0, DEPTH - 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1);
    chk("load_words_sat", 64'(load_words), 64'd16);
    for (int a = 0; a < DEPTH; a++) cpu_op(64'(a), 1'b1, 1'b0, '0, 1'b1);

    // Empty stream.
    ld_q.delete();
    load_seq(4'd7, 1'b0, 1'b0, 1'b0);
    chk("load_words_empty", 64'(load_words), 64'd0);
    repeat (40) rnd_op();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
